// File: rtl/tx_nibble_feeder_if.sv
// Host-side and sender-side signal bundle for tx_nibble_feeder.
// The master modport is the environment (host writer plus the sender's busy line).
interface tx_nibble_feeder_if #(
    parameter int AW = 3
);
    logic          wr_en;
    logic [3:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          tx_busy;
    logic          tx_send;
    logic [3:0]    tx_data;
    logic          retry_err;
    logic [7:0]    frames_sent;

    modport master (
        output wr_en, wr_data, tx_busy,
        input  full, empty, count, overflow, tx_send, tx_data, retry_err, frames_sent
    );

    modport slave (
        input  wr_en, wr_data, tx_busy,
        output full, empty, count, overflow, tx_send, tx_data, retry_err, frames_sent
    );
endinterface

// File: rtl/tx_nibble_feeder.sv
// Nibble FIFO feeding the serial sender: launches one frame at a time and
// retires a nibble only once the sender acknowledges it by raising busy.
module tx_nibble_feeder #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 4
) (
    input logic clk,
    input logic rst,
    tx_nibble_feeder_if.slave bus
);

    localparam logic [AW:0] DEPTH_C      = (AW + 1)'(DEPTH);
    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count_q;
    logic [AW:0]   count_next;
    logic          full_q;
    logic          empty_q;
    logic          overflow_q;

    logic          tx_send_q;
    logic [3:0]    tx_data_q;
    logic          retry_err_q;
    logic [7:0]    frames_q;
    logic [7:0]    timer;

    logic          wr_accept;
    logic          do_launch;
    logic          do_pop;
    logic          do_retry;
    logic          timer_clr;
    logic          timer_inc;

    // Acceptance looks at the registered full flag, so a same-cycle pop cannot rescue a write.
    assign wr_accept = bus.wr_en && !full_q;

    always_comb begin
        state_next = state;
        do_launch  = 1'b0;
        do_pop     = 1'b0;
        do_retry   = 1'b0;
        timer_clr  = 1'b0;
        timer_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty_q && !bus.tx_busy) begin
                    do_launch  = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                timer_clr  = 1'b1;
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.tx_busy) begin
                    do_pop     = 1'b1;
                    state_next = WAIT_DONE;
                end else if (timer == TIMEOUT_LAST) begin
                    do_retry   = 1'b1;
                    state_next = IDLE;
                end else begin
                    timer_inc  = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count_q;
        case ({wr_accept, do_pop})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (bus.wr_en && full_q) begin
                overflow_q <= 1'b1;
            end
            count_q <= count_next;
            full_q  <= (count_next == DEPTH_C);
            empty_q <= (count_next == '0);
        end
    end

    // tx_data is only reloaded at launch so it stays steady for the whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_send_q   <= 1'b0;
            tx_data_q   <= 4'd0;
            retry_err_q <= 1'b0;
            frames_q    <= 8'd0;
            timer       <= 8'd0;
        end else begin
            tx_send_q   <= do_launch;
            retry_err_q <= do_retry;
            if (do_launch) begin
                tx_data_q <= mem[rd_ptr];
            end
            if (do_pop) begin
                frames_q <= frames_q + 8'd1;
            end
            if (timer_clr) begin
                timer <= 8'd0;
            end else if (timer_inc) begin
                timer <= timer + 8'd1;
            end
        end
    end

    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.tx_send     = tx_send_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.retry_err   = retry_err_q;
    assign bus.frames_sent = frames_q;

endmodule

// File: tb/tb_tx_nibble_feeder.sv
// Self-checking bench for tx_nibble_feeder with a simple model of the sender's busy line.
`timescale 1ns/1ps
module tb_tx_nibble_feeder;

    typedef struct {
        logic       wr_en;
        logic [3:0] wr_data;
        int         exp_count;
        logic       exp_full;
        logic       exp_empty;
        logic       exp_overflow;
        logic       exp_tx_send;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force_busy = 1'b0;

    int checks = 0;
    int errors = 0;

    int busy_cnt = 0;
    int ignored = 0;
    int ignore_count = 0;

    logic [3:0] launch_log[$];
    int launch_count = 0;
    int retry_count = 0;
    int violations = 0;
    logic prev_send = 1'b0;

    vec_t vecs[12];

    tx_nibble_feeder_if #(.AW(3)) bus ();

    tx_nibble_feeder #(
        .DEPTH(8),
        .AW(3),
        .TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;

    // Sender model: samples TX_send, then holds busy for 8 cycles; can skip launches on request.
    always @(posedge clk) begin
        if (bus.tx_send && busy_cnt == 0) begin
            if (ignored < ignore_count) begin
                ignored <= ignored + 1;
            end else begin
                busy_cnt <= 8;
            end
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign bus.tx_busy = force_busy || (busy_cnt != 0);

    always @(posedge clk) begin
        if (bus.tx_send) begin
            launch_log.push_back(bus.tx_data);
            launch_count <= launch_count + 1;
            if (prev_send || bus.retry_err || bus.tx_busy) begin
                violations <= violations + 1;
            end
        end
        if (bus.retry_err) begin
            retry_count <= retry_count + 1;
        end
        prev_send <= bus.tx_send;
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        bus.wr_en   = v.wr_en;
        bus.wr_data = v.wr_data;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        bus.wr_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_burst(input logic [3:0] d0, input logic [3:0] d1,
                               input logic [3:0] d2, input logic [3:0] d3, input int n);
        logic [3:0] data [4];
        data[0] = d0; data[1] = d1; data[2] = d2; data[3] = d3;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.wr_en   = 1'b1;
            bus.wr_data = data[i];
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    initial begin
        int base;
        int lat;
        logic found;
        logic [3:0] exp_order [4];

        bus.wr_en   = 1'b0;
        bus.wr_data = 4'd0;

        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{1'b1, 4'(i + 1), i + 1, (i == 7), 1'b0, 1'b0, 1'b0};
        end
        vecs[8]  = '{1'b1, 4'd9, 8, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 4'd0, 8, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'd0, 8, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 4'd11, 8, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset values
        @(posedge clk);
        #1;
        check_output("reset count", int'(bus.count), 0);
        check_output("reset empty", int'(bus.empty), 1);
        check_output("reset full", int'(bus.full), 0);
        check_output("reset overflow", int'(bus.overflow), 0);
        check_output("reset tx_send", int'(bus.tx_send), 0);
        check_output("reset tx_data", int'(bus.tx_data), 0);
        check_output("reset retry_err", int'(bus.retry_err), 0);
        check_output("reset frames_sent", int'(bus.frames_sent), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] single frame");
        base = launch_count;
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = 4'd5;
        @(posedge clk);
        #1;
        check_output("single count after write", int'(bus.count), 1);
        check_output("single tx_send after E0", int'(bus.tx_send), 0);
        @(negedge clk);
        bus.wr_en = 1'b0;
        @(posedge clk);
        #1;
        check_output("single tx_send after E1", int'(bus.tx_send), 1);
        check_output("single tx_data after E1", int'(bus.tx_data), 5);
        repeat (16) @(posedge clk);
        #1;
        check_output("single launches", launch_count - base, 1);
        check_output("single launched data", int'(launch_log[base]), 5);
        check_output("single frames_sent", int'(bus.frames_sent), 1);
        check_output("single count end", int'(bus.count), 0);
        check_output("single empty end", int'(bus.empty), 1);

        $display("[TB] burst ordering");
        do_reset();
        base = launch_count;
        write_burst(4'd15, 4'd10, 4'd9, 4'd3, 4);
        repeat (60) @(posedge clk);
        #1;
        exp_order[0] = 4'd15; exp_order[1] = 4'd10; exp_order[2] = 4'd9; exp_order[3] = 4'd3;
        check_output("burst launches", launch_count - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < launch_log.size()) begin
                check_output($sformatf("burst order %0d", i), int'(launch_log[base + i]), int'(exp_order[i]));
            end else begin
                check_output($sformatf("burst order %0d missing", i), 0, 1);
            end
        end
        check_output("burst frames_sent", int'(bus.frames_sent), 4);
        check_output("burst empty", int'(bus.empty), 1);

        $display("[TB] full and overflow");
        do_reset();
        force_busy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("fill count v%0d", i), int'(bus.count), vecs[i].exp_count);
            check_output($sformatf("fill full v%0d", i), int'(bus.full), int'(vecs[i].exp_full));
            check_output($sformatf("fill empty v%0d", i), int'(bus.empty), int'(vecs[i].exp_empty));
            check_output($sformatf("fill overflow v%0d", i), int'(bus.overflow), int'(vecs[i].exp_overflow));
            check_output($sformatf("fill tx_send v%0d", i), int'(bus.tx_send), int'(vecs[i].exp_tx_send));
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
        do_reset();
        #1;
        check_output("overflow cleared by reset", int'(bus.overflow), 0);
        check_output("count cleared by reset", int'(bus.count), 0);
        force_busy = 1'b0;

        $display("[TB] timeout retry");
        do_reset();
        base = launch_count;
        ignore_count = ignored + 1;
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = 4'd12;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        @(posedge clk);
        #1;
        check_output("retry first tx_send", int'(bus.tx_send), 1);
        check_output("retry first tx_data", int'(bus.tx_data), 12);
        @(posedge clk);
        #1;
        check_output("retry launch ended", int'(bus.tx_send), 0);
        lat = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.retry_err) found = 1'b1;
        end
        check_output("retry_err seen", int'(found), 1);
        check_output("retry_err cycles after LAUNCH", lat, 4);
        @(posedge clk);
        #1;
        check_output("retry_err one cycle", int'(bus.retry_err), 0);
        check_output("relaunch tx_send", int'(bus.tx_send), 1);
        check_output("relaunch tx_data", int'(bus.tx_data), 12);
        repeat (16) @(posedge clk);
        #1;
        check_output("retry pulses", retry_count, 1);
        check_output("retry launches", launch_count - base, 2);
        check_output("retry frames_sent", int'(bus.frames_sent), 1);

        $display("[TB] simultaneous write and pop");
        do_reset();
        force_busy = 1'b1;
        base = launch_count;
        write_burst(4'd1, 4'd2, 4'd4, 4'd0, 3);
        #1;
        check_output("simul count before", int'(bus.count), 3);
        force_busy = 1'b0;
        @(posedge clk);
        #1;
        check_output("simul launch tx_send", int'(bus.tx_send), 1);
        check_output("simul launch tx_data", int'(bus.tx_data), 1);
        @(posedge clk);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = 4'd13;
        @(posedge clk);
        #1;
        check_output("simul count at ack", int'(bus.count), 3);
        check_output("simul frames at ack", int'(bus.frames_sent), 1);
        @(negedge clk);
        bus.wr_en = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        exp_order[0] = 4'd1; exp_order[1] = 4'd2; exp_order[2] = 4'd4; exp_order[3] = 4'd13;
        check_output("simul launches", launch_count - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < launch_log.size()) begin
                check_output($sformatf("simul order %0d", i), int'(launch_log[base + i]), int'(exp_order[i]));
            end else begin
                check_output($sformatf("simul order %0d missing", i), 0, 1);
            end
        end
        check_output("simul frames_sent", int'(bus.frames_sent), 4);

        $display("[TB] reset mid-frame");
        do_reset();
        write_burst(4'd7, 4'd8, 4'd6, 4'd0, 3);
        @(posedge clk);
        #1;
        check_output("midreset queued", int'(bus.count), 2);
        check_output("midreset busy", int'(bus.tx_busy), 1);
        @(negedge clk);
        force_busy = 1'b1;
        rst = 1'b1;
        #1;
        check_output("midreset count", int'(bus.count), 0);
        check_output("midreset empty", int'(bus.empty), 1);
        check_output("midreset tx_send", int'(bus.tx_send), 0);
        check_output("midreset frames_sent", int'(bus.frames_sent), 0);
        base = launch_count;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check_output("no launch while busy after reset", launch_count - base, 0);
        force_busy = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_output("no launch while empty after reset", launch_count - base, 0);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = 4'd14;
        @(negedge clk);
        bus.wr_en = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check_output("post-reset launches", launch_count - base, 1);
        if (base < launch_log.size()) begin
            check_output("post-reset data", int'(launch_log[base]), 14);
        end else begin
            check_output("post-reset data missing", 0, 1);
        end
        check_output("post-reset frames_sent", int'(bus.frames_sent), 1);

        check_output("protocol violations", violations, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
